// File: rtl/mem_module_pkg.sv
// Shared constants, FSM state type and width helper for the feature-map buffer.
package mem_module_pkg;

    localparam int unsigned NUMBER_OF_K = 4;
    localparam int unsigned BIT_SIZE    = 32;
    localparam int unsigned PROC_ELEMS  = 2;
    localparam int unsigned IMAGE_WIDTH = 2;

    localparam int unsigned PIX_PER_IMG = IMAGE_WIDTH * IMAGE_WIDTH;
    localparam int unsigned TOTAL_WORDS = NUMBER_OF_K * PIX_PER_IMG;
    localparam int unsigned WC_W        = $clog2(PIX_PER_IMG + 1);
    localparam int unsigned RP_W        = $clog2(TOTAL_WORDS);

    typedef enum logic {StFill, StDrain} mem_state_t;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_kernel_buf.sv
// Per-kernel image store: a register file filled in arrival order by a saturating write counter.
module mem_kernel_buf #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 32,
    parameter int unsigned CntW  = 3,
    parameter int unsigned AddrW = 2
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             clear,
    input  logic             we,
    input  logic [Width-1:0] wdata,
    input  logic [AddrW-1:0] raddr,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             last
);

    logic [Width-1:0] mem_q [Depth];
    logic [CntW-1:0]  wc_q, wc_d;
    logic             wr;

    assign full  = (wc_q == CntW'(Depth));
    assign last  = (wc_q == CntW'(Depth - 1));
    assign wr    = we && !full;
    assign rdata = mem_q[raddr];

    always_comb begin
        wc_d = wc_q;
        if (clear) begin
            wc_d = '0;
        end else if (wr) begin
            wc_d = wc_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            wc_q <= '0;
        end else begin
            wc_q <= wc_d;
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[AddrW'(wc_q)] <= wdata;
        end
    end

endmodule

// File: rtl/mem_module.sv
// Feature-map buffer: collects one image per kernel from the PE lanes, then streams all
// images out kernel-major, one registered word per cycle.
module mem_module
    import mem_module_pkg::*;
#(
    parameter int unsigned NumberOfK          = NUMBER_OF_K,
    parameter int unsigned BitSize            = BIT_SIZE,
    parameter int unsigned ProcessingElements = PROC_ELEMS,
    parameter int unsigned ImageWidth         = IMAGE_WIDTH
) (
    input  logic                               clk,
    input  logic                               res_n,
    input  logic [NumberOfK-1:0]               in_valid,
    input  logic [ProcessingElements*BitSize-1:0] in_data,
    output logic [BitSize-1:0]                 out_data,
    output logic                               out_valid,
    output logic                               image_done
);

    localparam int unsigned PixPerImg  = ImageWidth * ImageWidth;
    localparam int unsigned TotalWords = NumberOfK * PixPerImg;
    localparam int unsigned WcW        = $clog2(PixPerImg + 1);
    localparam int unsigned RpW        = width_of(TotalWords);
    localparam int unsigned AddrW      = width_of(PixPerImg);
    localparam int unsigned KerW       = width_of(NumberOfK);

    mem_state_t          state_q, state_d;
    logic [RpW-1:0]      rp_q, rp_d;
    logic [BitSize-1:0]  out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                image_done_q, image_done_d;

    logic [NumberOfK-1:0] we, full, last, done_next;
    logic                 clear;
    logic [AddrW-1:0]     rd_pix;
    logic [KerW-1:0]      rd_ker;
    logic [BitSize-1:0]   rdata [NumberOfK];

    for (genvar k = 0; k < NumberOfK; k++) begin : g_kernel
        assign we[k]        = (state_q == StFill) && in_valid[k];
        // Kernel is complete after this edge if already full or taking its final pixel now.
        assign done_next[k] = full[k] || (we[k] && last[k]);

        mem_kernel_buf #(
            .Depth (PixPerImg),
            .Width (BitSize),
            .CntW  (WcW),
            .AddrW (AddrW)
        ) u_buf (
            .clk   (clk),
            .res_n (res_n),
            .clear (clear),
            .we    (we[k]),
            .wdata (in_data[(k % ProcessingElements) * BitSize +: BitSize]),
            .raddr (rd_pix),
            .rdata (rdata[k]),
            .full  (full[k]),
            .last  (last[k])
        );
    end

    always_comb begin
        rd_pix       = AddrW'(32'(rp_q) % PixPerImg);
        rd_ker       = KerW'(32'(rp_q) / PixPerImg);
        state_d      = state_q;
        rp_d         = rp_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        image_done_d = image_done_q;
        clear        = 1'b0;
        unique case (state_q)
            StFill: begin
                if (&done_next) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // The cycle after the final word returns to fill and rearms every counter.
                if (image_done_q) begin
                    state_d      = StFill;
                    clear        = 1'b1;
                    rp_d         = '0;
                    out_valid_d  = 1'b0;
                    image_done_d = 1'b0;
                end else begin
                    out_data_d   = rdata[rd_ker];
                    out_valid_d  = 1'b1;
                    image_done_d = (rp_q == RpW'(TotalWords - 1));
                    rp_d         = rp_q + RpW'(1);
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q      <= StFill;
            rp_q         <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            image_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rp_q         <= rp_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            image_done_q <= image_done_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign image_done = image_done_q;

endmodule

// File: tb/tb_mem_module.sv
// Directed bench for mem_module: fill patterns, drain order/timing, dropped pixels, resets.
module tb_mem_module;

    logic        clk;
    logic        res_n;
    logic [3:0]  in_valid;
    logic [63:0] in_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        image_done;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_w [16];

    mem_module dut (
        .clk        (clk),
        .res_n      (res_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .image_done (image_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Present one cycle of input; {lane1, lane0}.
    task automatic drive(input logic [3:0] v, input logic [31:0] l1, input logic [31:0] l0);
        in_valid = v;
        in_data  = {l1, l0};
        tick();
    endtask

    // Kernels 0/1 take {1,2}, kernels 2/3 take {3,4}.
    task automatic load_default();
        for (int r = 0; r < 4; r++) begin
            drive(4'b0011, 32'd1, 32'd2);
            drive(4'b1100, 32'd3, 32'd4);
        end
        in_valid = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            exp_w[i] = (i < 4) ? 32'd2 : (i < 8) ? 32'd1 : (i < 12) ? 32'd4 : 32'd3;
        end
    endtask

    // Kernel k pixel p carries 10k+p.
    task automatic load_indexed();
        for (int p = 0; p < 4; p++) begin
            drive(4'b0011, 32'(10 + p), 32'(p));
            drive(4'b1100, 32'(30 + p), 32'(20 + p));
        end
        in_valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 4; p++) begin
                exp_w[k*4+p] = 32'(10 * k + p);
            end
        end
    endtask

    // Entered one sample after the final write edge.
    task automatic drain_check(input string tag);
        check({tag, "_latency"}, {31'b0, out_valid}, 32'd0);
        tick();
        for (int i = 0; i < 16; i++) begin
            check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
            check({tag, "_data"}, out_data, exp_w[i]);
            check({tag, "_done"}, {31'b0, image_done}, (i == 15) ? 32'd1 : 32'd0);
            tick();
        end
        check({tag, "_end_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_end_done"}, {31'b0, image_done}, 32'd0);
        check({tag, "_hold"}, out_data, exp_w[15]);
    endtask

    initial begin
        res_n    = 1'b0;
        in_valid = 4'b0000;
        in_data  = '0;

        // Reset
        tick();
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_done", {31'b0, image_done}, 32'd0);
        check("rst_data", out_data, 32'd0);
        res_n = 1'b1;
        tick();

        // Default lane pattern
        load_default();
        drain_check("default");

        // Arrival order preserved
        load_indexed();
        drain_check("indexed");

        // All lanes at once; kernels 0/2 share lane 0, 1/3 share lane 1
        for (int p = 0; p < 4; p++) begin
            drive(4'b1111, 32'(200 + p), 32'(100 + p));
        end
        in_valid = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            exp_w[i] = ((i / 4) % 2 == 0) ? 32'(100 + i % 4) : 32'(200 + i % 4);
        end
        drain_check("all_lanes");

        // Extra pixels to full kernels, junk during drain
        for (int p = 0; p < 4; p++) begin
            drive(4'b0011, 32'(60 + p), 32'(50 + p));
        end
        drive(4'b0011, 32'd99, 32'd98);
        drive(4'b0011, 32'd97, 32'd96);
        check("overfill_no_drain", {31'b0, out_valid}, 32'd0);
        for (int p = 0; p < 4; p++) begin
            drive(4'b1100, 32'(80 + p), 32'(70 + p));
        end
        in_valid = 4'b1111;
        in_data  = {32'hdead_beef, 32'hcafe_f00d};
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 4; p++) begin
                exp_w[k*4+p] = 32'(50 + 10 * k + p);
            end
        end
        drain_check("overfill");
        in_valid = 4'b0000;

        // Second full load streams again
        load_default();
        drain_check("reload");

        // Reset in the middle of drain
        load_default();
        check("mid_latency", {31'b0, out_valid}, 32'd0);
        tick();
        check("mid_first_valid", {31'b0, out_valid}, 32'd1);
        check("mid_first_data", out_data, 32'd2);
        tick();
        res_n = 1'b0;
        tick();
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_done", {31'b0, image_done}, 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        res_n = 1'b1;
        tick();
        load_indexed();
        drain_check("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
